// File: rtl/ssd_message_scroller_pkg.sv
// Shared types and constants for the seven-segment message scroller.
package ssd_message_scroller_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned DIGITS = 4;
  localparam logic [CHAR_W-1:0] BLANK = 8'h00;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/ssd_scroll_tick.sv
// Step-rate divider: counts 0..STEP_COUNTS-1 while enabled, with a one-cycle
// tick on the terminal count. Disabling freezes the count mid-period.
module ssd_scroll_tick #(
  parameter int unsigned STEP_COUNTS = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (STEP_COUNTS > 1) ? $clog2(STEP_COUNTS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_COUNTS - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && !clr && (cnt_q == TERM);

  // Counter: clear wins, otherwise advance/reload while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == TERM) cnt_q <= '0;
      else               cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ssd_message_scroller.sv
// Message buffer and scroller feeding the 4-digit seven-segment controller.
// Short messages (<=4 chars) are shown static and left-aligned; longer ones
// scroll left with GAP blanks between repeats.
module ssd_message_scroller
  import ssd_message_scroller_pkg::*;
#(
  parameter int unsigned       MAX_CHARS   = 32,
  parameter int unsigned       GAP         = 4,
  parameter int unsigned       STEP_COUNTS = 25_000_000,
  parameter logic [CHAR_W-1:0] BLANK_CHAR  = BLANK
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [CHAR_W-1:0]        wr_char,
  output logic                     wr_ready,
  input  logic                     commit,
  input  logic                     pause,
  output logic [DIGITS*CHAR_W-1:0] word,
  output logic                     scrolling,
  output logic                     wrap
);

  localparam int unsigned LEN_W  = $clog2(MAX_CHARS + 1);
  localparam int unsigned OFF_W  = $clog2(MAX_CHARS + GAP + 4);
  localparam int unsigned ADDR_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_CHARS);
  localparam logic [LEN_W-1:0] LEN_STATIC = LEN_W'(DIGITS);

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [OFF_W-1:0]         off_q, off_d;
  logic                     wrap_d;
  logic                     wr_ok_c;
  logic                     tick_c;
  logic                     tick_en_c;
  logic                     tick_clr_c;
  logic [OFF_W-1:0]         period_c;
  logic [DIGITS*CHAR_W-1:0] word_c;
  logic [OFF_W-1:0]         idx;
  logic [CHAR_W-1:0]        buf_q [MAX_CHARS];

  assign period_c   = OFF_W'(len_q) + OFF_W'(GAP);
  assign tick_en_c  = (state_q == ST_SHOW) && (len_q > LEN_STATIC) && !pause;
  assign tick_clr_c = clear || (state_q == ST_LOAD);

  ssd_scroll_tick #(
    .STEP_COUNTS (STEP_COUNTS)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (tick_en_c),
    .clr    (tick_clr_c),
    .tick_c (tick_c)
  );

  // State, length and offset registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      len_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
    end
  end

  // Next-state: loading, commit, offset advance and wrap detection.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    wrap_d  = 1'b0;
    wr_ok_c = 1'b0;
    if (clear) begin
      state_d = ST_LOAD;
      len_d   = '0;
      off_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          wr_ok_c = wr_en && (len_q < LEN_MAX);
          if (wr_ok_c) len_d = len_q + LEN_W'(1);
          if (commit && (len_d != '0)) begin
            state_d = ST_SHOW;
            off_d   = '0;
          end
        end
        ST_SHOW: begin
          if (tick_c) begin
            if (off_q == period_c - OFF_W'(1)) begin
              off_d  = '0;
              wrap_d = 1'b1;
            end else begin
              off_d = off_q + OFF_W'(1);
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Character buffer; unused slots are masked at assembly so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok_c) buf_q[len_q[ADDR_W-1:0]] <= wr_char;
  end

  // Window assembly: four consecutive positions of the circular message+gap.
  always_comb begin
    word_c = {DIGITS{BLANK_CHAR}};
    idx    = '0;
    if (state_q == ST_SHOW) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        idx = off_q + OFF_W'(i);
        if ((len_q > LEN_STATIC) && (idx >= period_c)) idx = idx - period_c;
        if (idx < OFF_W'(len_q)) begin
          word_c[(DIGITS-1-i)*CHAR_W +: CHAR_W] = buf_q[idx[ADDR_W-1:0]];
        end
      end
    end
  end

  // Registered outputs; clear blanks the word on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word      <= {DIGITS{BLANK_CHAR}};
      wr_ready  <= 1'b0;
      scrolling <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      word      <= clear ? {DIGITS{BLANK_CHAR}} : word_c;
      wr_ready  <= (state_d == ST_LOAD) && (len_d < LEN_MAX);
      scrolling <= (state_d == ST_SHOW) && (len_d > LEN_STATIC);
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_ssd_message_scroller.sv
// Directed bench for ssd_message_scroller (STEP_COUNTS=4, GAP=4, MAX_CHARS=8).
module tb_ssd_message_scroller;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        wr_en;
  logic [7:0]  wr_char;
  logic        wr_ready;
  logic        commit;
  logic        pause;
  logic [31:0] word;
  logic        scrolling;
  logic        wrap;

  int checks   = 0;
  int errors   = 0;
  int wrap_cnt = 0;

  logic [31:0] exp_scroll [9];

  ssd_message_scroller #(
    .MAX_CHARS   (8),
    .GAP         (4),
    .STEP_COUNTS (4),
    .BLANK_CHAR  (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .commit    (commit),
    .pause     (pause),
    .word      (word),
    .scrolling (scrolling),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic write_char(input logic [7:0] c);
    wr_en   = 1'b1;
    wr_char = c;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    exp_scroll[0] = 32'h41424344;
    exp_scroll[1] = 32'h42434445;
    exp_scroll[2] = 32'h43444500;
    exp_scroll[3] = 32'h44450000;
    exp_scroll[4] = 32'h45000000;
    exp_scroll[5] = 32'h00000000;
    exp_scroll[6] = 32'h00000041;
    exp_scroll[7] = 32'h00004142;
    exp_scroll[8] = 32'h00414243;

    reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_char = 8'h00;
    commit = 1'b0; pause = 1'b0;

    // Power-on reset
    #12;
    check("reset_word", word, 32'h0);
    check("reset_wr_ready", 32'(wr_ready), 32'h0);
    check("reset_scrolling", 32'(scrolling), 32'h0);
    reset = 1'b0;
    step();
    check("wr_ready_after_reset", 32'(wr_ready), 32'h1);

    // Static two-character message
    write_char(8'h41);
    write_char(8'h42);
    do_commit();
    step();
    check("static_word", word, 32'h41420000);
    check("static_scrolling", 32'(scrolling), 32'h0);
    check("static_wr_ready", 32'(wr_ready), 32'h0);
    wrap_cnt = 0;
    repeat (100) step();
    check("static_no_wrap", 32'(wrap_cnt), 32'h0);
    check("static_word_held", word, 32'h41420000);
    do_clear();
    check("clear_show_word", word, 32'h0);

    // Five-character scroll through a full period
    for (int c = 0; c < 5; c++) write_char(8'(8'h41 + c));
    do_commit();
    step();
    check("scroll_off0", word, exp_scroll[0]);
    check("scroll_flag", 32'(scrolling), 32'h1);
    wrap_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      repeat (4) step();
      check($sformatf("scroll_step%0d", k), word, exp_scroll[k % 9]);
    end
    check("scroll_wrap_count", 32'(wrap_cnt), 32'h1);

    // Asynchronous reset mid-scroll
    repeat (6) step();
    #2 reset = 1'b1;
    #1;
    check("midreset_word", word, 32'h0);
    check("midreset_scrolling", 32'(scrolling), 32'h0);
    check("midreset_wrap", 32'(wrap), 32'h0);
    reset = 1'b0;
    step();
    check("midreset_wr_ready", 32'(wr_ready), 32'h1);
    check("midreset_word_after", word, 32'h0);

    // Pause holds position; release resumes with the remaining count
    for (int c = 0; c < 5; c++) write_char(8'(8'h41 + c));
    do_commit();
    step();
    check("pause_off0", word, 32'h41424344);
    step();
    pause = 1'b1;
    repeat (20) step();
    check("pause_held", word, 32'h41424344);
    pause = 1'b0;
    step();
    step();
    check("pause_release_early", word, 32'h41424344);
    step();
    check("pause_release_step", word, 32'h42434445);
    do_clear();

    // Overflow: ninth character dropped
    for (int c = 0; c < 8; c++) write_char(8'(8'h61 + c));
    check("full_wr_ready", 32'(wr_ready), 32'h0);
    write_char(8'h69);
    do_commit();
    step();
    check("full_off0", word, 32'h61626364);
    repeat (20) step();
    check("full_off5", word, 32'h66676800);
    do_clear();

    // clear beats a same-cycle write; commit on empty buffer ignored
    write_char(8'h31);
    write_char(8'h32);
    write_char(8'h33);
    clear = 1'b1; wr_en = 1'b1; wr_char = 8'h34;
    step();
    clear = 1'b0; wr_en = 1'b0;
    check("clear_wr_word", word, 32'h0);
    check("clear_wr_ready", 32'(wr_ready), 32'h1);
    do_commit();
    step();
    check("empty_commit_ready", 32'(wr_ready), 32'h1);
    check("empty_commit_word", word, 32'h0);
    write_char(8'h41);
    do_commit();
    step();
    check("after_clear_word", word, 32'h41000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
